// File: rtl/reg_file_scoreboard.sv
// Per-register pending-write scoreboard: gates issue on RAW hazards and on a full per-register counter (WAW).
// Latency: issue_ready is combinational from registered counters; writebacks clear hazards one cycle later.
// Backpressure: issue_ready drops on hazard, full rd counter or flush, independent of issue_valid.
module reg_file_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int MAX_PENDING = 3,
    parameter int STALL_CNT_W = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic                        issue_uses_rs1,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rs1,
    input  logic                        issue_uses_rs2,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rs2,
    input  logic                        issue_writes_rd,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
    input  logic                        wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd,
    input  logic                        flush,
    output logic [NUM_REGS-1:0]         busy_mask,
    output logic                        underflow_err,
    output logic [STALL_CNT_W-1:0]      stall_cycles
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING);

    logic [CW-1:0] count [NUM_REGS];
    logic          haz1;
    logic          haz2;
    logic          full;
    logic          fire;

    always_comb begin
        busy_mask = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            busy_mask[i] = (count[i] != '0);
        end
    end

    // No writeback bypass: hazards look only at the registered counters.
    always_comb begin
        haz1        = issue_uses_rs1  && (issue_rs1 != '0) && busy_mask[issue_rs1];
        haz2        = issue_uses_rs2  && (issue_rs2 != '0) && busy_mask[issue_rs2];
        full        = issue_writes_rd && (issue_rd  != '0) && (count[issue_rd] == CNT_MAX);
        issue_ready = !(haz1 || haz2 || full) && !flush;
        fire        = issue_valid && issue_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                count[i] <= '0;
            end
            underflow_err <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            if (issue_valid && !issue_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            count[0] <= '0;
            if (flush) begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    count[i] <= '0;
                end
            end else begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (fire && issue_writes_rd && (issue_rd == AW'(i))) begin
                        if (!(wb_valid && (wb_rd == AW'(i)) && (count[i] != '0))) begin
                            count[i] <= count[i] + 1'b1;
                        end
                    end else if (wb_valid && (wb_rd == AW'(i)) && (count[i] != '0)) begin
                        count[i] <= count[i] - 1'b1;
                    end
                end
                if (wb_valid && (wb_rd != '0) && (count[wb_rd] == '0)) begin
                    underflow_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: directed scenarios with literal pins, then random traffic against a counter-array model.
module tb_reg_file_scoreboard;
    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_uses_rs1;
    logic [4:0]  issue_rs1;
    logic        issue_uses_rs2;
    logic [4:0]  issue_rs2;
    logic        issue_writes_rd;
    logic [4:0]  issue_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_mask;
    logic        underflow_err;
    logic [31:0] stall_cycles;

    int compared   = 0;
    int mismatched = 0;

    int     mcnt [32];
    bit     muf;
    longint mstall;

    reg_file_scoreboard dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_uses_rs1  (issue_uses_rs1),
        .issue_rs1       (issue_rs1),
        .issue_uses_rs2  (issue_uses_rs2),
        .issue_rs2       (issue_rs2),
        .issue_writes_rd (issue_writes_rd),
        .issue_rd        (issue_rd),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .flush           (flush),
        .busy_mask       (busy_mask),
        .underflow_err   (underflow_err),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        reset = 0; issue_valid = 0; issue_uses_rs1 = 0; issue_rs1 = 0;
        issue_uses_rs2 = 0; issue_rs2 = 0; issue_writes_rd = 0; issue_rd = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic model_clear();
        foreach (mcnt[i]) mcnt[i] = 0;
    endtask

    function automatic bit model_ready();
        bit h1, h2, f;
        h1 = issue_uses_rs1  && issue_rs1 != 0 && mcnt[issue_rs1] != 0;
        h2 = issue_uses_rs2  && issue_rs2 != 0 && mcnt[issue_rs2] != 0;
        f  = issue_writes_rd && issue_rd  != 0 && mcnt[issue_rd] == 3;
        return !(h1 || h2 || f) && !flush;
    endfunction

    // Compare every output against the model, advance the model, then run one clock.
    task automatic tick();
        bit          er;
        logic [31:0] eb;
        int          old;
        #1;
        er = model_ready();
        eb = '0;
        for (int i = 0; i < 32; i++) eb[i] = (mcnt[i] != 0);
        chk("issue_ready", issue_ready, er);
        chk("busy_mask", busy_mask, eb);
        chk("underflow_err", underflow_err, muf);
        chk("stall_cycles", stall_cycles, mstall[31:0]);
        if (reset) begin
            model_clear(); muf = 0; mstall = 0;
        end else begin
            if (issue_valid && !er && mstall < 64'hFFFF_FFFF) mstall++;
            if (flush) model_clear();
            else begin
                old = mcnt[wb_rd];
                if (issue_valid && er && issue_writes_rd && issue_rd != 0) mcnt[issue_rd]++;
                if (wb_valid && wb_rd != 0) begin
                    if (old == 0) muf = 1;
                    else mcnt[wb_rd]--;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        idle(); issue_valid = 1; issue_writes_rd = 1; issue_rd = rd; tick();
    endtask

    task automatic wb(input logic [4:0] rd);
        idle(); wb_valid = 1; wb_rd = rd; tick();
    endtask

    initial begin
        model_clear(); muf = 0; mstall = 0;
        idle();
        reset = 1;
        @(posedge clk); @(negedge clk);
        idle(); #1;
        chk("rst_busy", busy_mask, 0);
        chk("rst_ready", issue_ready, 1);
        chk("rst_uf", underflow_err, 0);
        chk("rst_stall", stall_cycles, 0);
        tick();

        // RAW on x5, cleared one cycle after writeback
        issue_wr(5);
        idle(); issue_valid = 1; issue_uses_rs1 = 1; issue_rs1 = 5; #1;
        chk("raw_ready", issue_ready, 0);
        chk("raw_busy", busy_mask, 32'h20);
        tick();
        wb_valid = 1; wb_rd = 5; #1;
        chk("raw_nobypass", issue_ready, 0);
        tick();
        wb_valid = 0; #1;
        chk("raw_clear_ready", issue_ready, 1);
        chk("raw_clear_busy", busy_mask, 0);
        tick();

        // x0 never pending; unused rs2 ignored
        issue_wr(0);
        idle(); issue_valid = 1; issue_uses_rs1 = 1; issue_rs1 = 0; #1;
        chk("x0_busy", busy_mask, 0);
        chk("x0_ready", issue_ready, 1);
        tick();
        issue_wr(7);
        idle(); issue_valid = 1; issue_uses_rs2 = 0; issue_rs2 = 7; #1;
        chk("unused_rs2_ready", issue_ready, 1);
        tick();
        wb(7);

        // WAW full at MAX_PENDING on x3
        repeat (3) issue_wr(3);
        idle(); issue_valid = 1; issue_writes_rd = 1; issue_rd = 3; #1;
        chk("full_ready", issue_ready, 0);
        tick(); tick();
        wb_valid = 1; wb_rd = 3; tick();
        wb_valid = 0; #1;
        chk("full_stall", stall_cycles, 5);
        chk("full_release", issue_ready, 1);
        tick();
        idle(); issue_valid = 1; issue_writes_rd = 1; issue_rd = 3; #1;
        chk("full_again", issue_ready, 0);
        idle();
        repeat (3) wb(3);

        // simultaneous issue and writeback on x9
        issue_wr(9);
        idle(); issue_valid = 1; issue_writes_rd = 1; issue_rd = 9; wb_valid = 1; wb_rd = 9; tick();
        idle(); #1;
        chk("same_cycle_busy9", busy_mask[9], 1);
        wb(9);

        // underflow on x12 is sticky
        wb(12);
        idle(); #1;
        chk("uf_set", underflow_err, 1);
        repeat (10) tick();
        chk("uf_sticky", underflow_err, 1);
        chk("uf_busy", busy_mask, 0);

        // flush with pending x4/x8
        issue_wr(4); issue_wr(8);
        idle(); issue_valid = 1; flush = 1; #1;
        chk("flush_ready", issue_ready, 0);
        tick();
        idle(); #1;
        chk("flush_busy", busy_mask, 0);
        chk("flush_uf_kept", underflow_err, 1);

        // reset in the middle of a stall
        issue_wr(4);
        idle(); issue_valid = 1; issue_uses_rs1 = 1; issue_rs1 = 4; tick();
        reset = 1; tick();
        idle(); #1;
        chk("midrst_busy", busy_mask, 0);
        chk("midrst_uf", underflow_err, 0);
        chk("midrst_stall", stall_cycles, 0);
        chk("midrst_ready", issue_ready, 1);
        tick();

        // random traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            idle();
            issue_valid     = ($urandom_range(0, 9) < 7);
            issue_uses_rs1  = $urandom_range(0, 1);
            issue_rs1       = 5'($urandom_range(0, 7));
            issue_uses_rs2  = $urandom_range(0, 1);
            issue_rs2       = 5'($urandom_range(0, 7));
            issue_writes_rd = $urandom_range(0, 1);
            issue_rd        = 5'($urandom_range(0, 7));
            wb_valid        = ($urandom_range(0, 9) < 4);
            wb_rd           = 5'($urandom_range(0, 7));
            flush           = ($urandom_range(0, 99) < 2);
            reset           = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Tracks outstanding register writes in flight between issue and writeback, and gates instruction issue on read-after-write and write-after-write hazards.
- Sits between decode and the register file read stage. Consumes the decoded rs1/rs2/rd addresses and produces the issue-ready handshake that sequences register file reads.
- Holds a per-register pending-write counter. x0 is never pending.

Parameters:
- NUM_REGS, 32, number of architectural registers; address width is clog2(NUM_REGS).
- MAX_PENDING, 3, maximum outstanding writes per register; counter width is clog2(MAX_PENDING+1).
- STALL_CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  instruction may issue this cycle
- issue_uses_rs1  in  1  instruction reads rs1
- issue_rs1  in  5  rs1 address (already forced to x0 for LUI/CSRxxI by decode)
- issue_uses_rs2  in  1  instruction reads rs2
- issue_rs2  in  5  rs2 address
- issue_writes_rd  in  1  instruction writes rd
- issue_rd  in  5  rd address
- wb_valid  in  1  a writeback completes this cycle
- wb_rd  in  5  writeback destination
- flush  in  1  pipeline flush; discard all pending state
- busy_mask  out  NUM_REGS  bit i = count[i] != 0
- underflow_err  out  1  sticky: writeback to a register with zero pending
- stall_cycles  out  STALL_CNT_W  cycles with issue_valid & !issue_ready

Behaviour:
- Clock and reset:
  - One clock, clk. reset is synchronous and active-high.
  - On reset: all counters = 0, busy_mask = 0, underflow_err = 0, stall_cycles = 0.
  - issue_ready follows its combinational definition (1 for any legal input once counters are 0).
- Hazard terms (combinational from registered counters; no same-cycle writeback bypass):
  - haz1 = issue_uses_rs1 & (issue_rs1 != 0) & busy[issue_rs1]
  - haz2 = issue_uses_rs2 & (issue_rs2 != 0) & busy[issue_rs2]
  - full = issue_writes_rd & (issue_rd != 0) & (count[issue_rd] == MAX_PENDING)
- issue_ready = !(haz1 | haz2 | full) & !flush.
- issue_ready does not depend on issue_valid. No combinational path from issue_valid to issue_ready.
- fire = issue_valid & issue_ready.
- Counter update for register r != 0, per cycle:
  - inc = fire & issue_writes_rd & (issue_rd == r)
  - dec = wb_valid & (wb_rd == r) & (count[r] != 0)
  - inc & dec: count unchanged. inc only: +1. dec only: -1.
- Writes to x0 are ignored; count[0] is always 0 and busy_mask[0] is always 0.
- wb_valid to a register with count 0 (r != 0): no counter change; underflow_err is set next cycle and stays 1 until reset.
- A writeback in cycle N clears the hazard starting cycle N+1. Issue latency after the producing writeback is 1 cycle.
- flush:
  - All counters clear to 0 next cycle.
  - issue_ready = 0 during the flush cycle.
  - wb_valid in the same cycle is ignored (no underflow flagged).
  - underflow_err and stall_cycles are unchanged.
- stall_cycles increments by 1 each cycle issue_valid & !issue_ready, including flush cycles. Saturates at all-ones and does not wrap.
- busy_mask is registered: it reflects the counters after the clock edge.
- reset has priority over flush. A flush in the same cycle as reset has no additional effect.

Test Plan:
- Reset, then issue rd=5 (fire), next cycle present rs1=5 uses_rs1=1 -> issue_ready=0, busy_mask=0x20. wb_valid rd=5 -> following cycle issue_ready=1, busy_mask=0.
- Issue rd=0 writes_rd=1, then rs1=0 -> busy_mask stays 0, issue_ready=1 throughout. Also rs2=7 with uses_rs2=0 while x7 busy -> issue_ready=1.
- Three fires to rd=3 (MAX_PENDING=3), fourth writes rd=3 -> issue_ready=0, stall_cycles increments each cycle. One wb rd=3 -> fourth fires next cycle, count stays 3.
- Same cycle fire rd=9 and wb rd=9 with count[9]=1 -> count[9] remains 1, busy_mask[9]=1.
- wb_valid rd=12 with count 0 -> underflow_err=1 next cycle, still 1 after 10 idle cycles, counters unchanged.
- Pending writes on x4 and x8, assert flush one cycle with issue_valid=1 -> issue_ready=0, stall_cycles+1, busy_mask=0 next cycle. Reset mid-stall -> all outputs at reset values next cycle.
